cbus_ram_responder: RTL and testbench

Word-organized RAM that sits at the responder end of the CBus and serves single and burst transactions issued by an initiator, typically the output side of the CBus arbiter. It accepts one request at a time, then drives one `ready` pulse per beat and `last` on the final beat. It reads and writes an internal array and supports FIXED, INCR and WRAP bursts. A configurable per-beat stall emulates slow memory for system-level testing.

---
 rtl/cbus_ram_responder.sv | 135 +++++++++++++
 tb/tb_cbus_ram_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_ram_responder.sv
// CBus responder RAM: serves single/burst reads and writes (FIXED, INCR, WRAP) from a word array.
// Latency: first beat STALL_CYCLES+1 cycles after acceptance, STALL_CYCLES idle cycles before every beat.
// Backpressure: none; dropping valid mid-transaction aborts it, one request is held at a time.
package cbus_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [3:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;
endpackage

module cbus_ram_responder
    import cbus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int STALL_CYCLES = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  cbus_req_t  ireq,
    output cbus_resp_t oresp
);
    typedef enum logic [1:0] {IDLE, STALL, BEAT} state_t;

    state_t                  state;
    logic                    is_write_q;
    logic [3:0]              len_q;
    logic [3:0]              beat_q;
    logic [3:0]              stall_q;
    logic [1:0]              burst_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [ADDR_WIDTH-1:0]   next_idx;
    logic [ADDR_WIDTH-1:0]   win_mask;
    logic                    wrap_ok;
    logic                    beat_fire;
    logic                    is_last;
    logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];

    logic unused_req_bits;
    assign unused_req_bits = ^{ireq.size, ireq.addr[31:ADDR_WIDTH+2], ireq.addr[1:0]};

    // A beat only counts while the initiator still holds valid; a dropped valid aborts it.
    assign beat_fire = (state == BEAT) && ireq.valid;
    assign is_last   = (beat_q == len_q);
    assign wrap_ok   = (burst_q == 2'd2) && (len_q inside {4'd1, 4'd3, 4'd7, 4'd15});
    assign win_mask  = ADDR_WIDTH'(len_q);

    always_comb begin
        next_idx = idx_q + ADDR_WIDTH'(1);
        if (burst_q == 2'd0) begin
            next_idx = idx_q;
        end else if (wrap_ok) begin
            next_idx = (idx_q & ~win_mask) | ((idx_q + ADDR_WIDTH'(1)) & win_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            is_write_q <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            stall_q    <= '0;
            burst_q    <= '0;
            idx_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ireq.valid) begin
                        is_write_q <= ireq.is_write;
                        len_q      <= ireq.len;
                        burst_q    <= ireq.burst;
                        idx_q      <= ireq.addr[ADDR_WIDTH+1:2];
                        beat_q     <= '0;
                        stall_q    <= '0;
                        state      <= (STALL_CYCLES > 0) ? STALL : BEAT;
                    end
                end
                STALL: begin
                    if (!ireq.valid) begin
                        state <= IDLE;
                    end else if (stall_q == 4'(STALL_CYCLES - 1)) begin
                        state <= BEAT;
                    end else begin
                        stall_q <= stall_q + 4'd1;
                    end
                end
                BEAT: begin
                    if (!ireq.valid || is_last) begin
                        state <= IDLE;
                    end else begin
                        beat_q  <= beat_q + 4'd1;
                        idx_q   <= next_idx;
                        stall_q <= '0;
                        state   <= (STALL_CYCLES > 0) ? STALL : BEAT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Contents are never reset; a reset edge only suppresses the write of the beat it lands on.
    always_ff @(posedge clk) begin
        if (resetn && beat_fire && is_write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (ireq.strobe[i]) begin
                    mem[idx_q][8*i +: 8] <= ireq.data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        oresp = '0;
        if (beat_fire) begin
            oresp.ready = 1'b1;
            oresp.last  = is_last;
            if (!is_write_q) begin
                oresp.data = mem[idx_q];
            end
        end
    end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// Randomized and directed bench for cbus_ram_responder, unit 0 without stall and unit 1 with two stall cycles.
module tb_cbus_ram_responder;
    import cbus_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    cbus_req_t  req [2];
    cbus_resp_t resp [2];

    cbus_ram_responder #(.ADDR_WIDTH(10), .STALL_CYCLES(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .ireq(req[0]), .oresp(resp[0]));
    cbus_ram_responder #(.ADDR_WIDTH(10), .STALL_CYCLES(2)) u_dut1 (
        .clk(clk), .resetn(resetn), .ireq(req[1]), .oresp(resp[1]));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int npass = 0;
    int ntot  = 0;

    // reference model: per-unit word store plus per-byte "has been written" flags
    logic [31:0] mmem [2][1024];
    logic [3:0]  mdef [2][1024];

    cbus_resp_t  exp_r [2];
    logic [31:0] exp_m [2];
    bit          chk [2];

    logic [31:0] wd_q [$];
    logic [3:0]  ws_q [$];
    logic [31:0] want_q [$];
    logic [31:0] pred_q [$];
    logic [31:0] obs_q [$];
    int          rdy_q [$];
    int          t_acc;

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (resp[u].ready) begin
                obs_q.push_back(resp[u].data);
                rdy_q.push_back(cyc);
            end
            if (chk[u]) begin
                ntot++;
                if (resp[u].ready === exp_r[u].ready && resp[u].last === exp_r[u].last &&
                    (resp[u].data & exp_m[u]) === (exp_r[u].data & exp_m[u])) begin
                    npass++;
                end else begin
                    $display("FAIL resp_u%0d cyc=%0d got ready=%b last=%b data=%h want ready=%b last=%b data=%h mask=%h",
                             u, cyc, resp[u].ready, resp[u].last, resp[u].data,
                             exp_r[u].ready, exp_r[u].last, exp_r[u].data, exp_m[u]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        ntot++;
        if (got === want) npass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    function automatic int widx(input int s, input int k, input int len, input int burst);
        int w;
        int base;
        if (burst == 0) return s;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            w    = len + 1;
            base = s - (s % w);
            return base + ((s - base + k) % w);
        end
        return (s + k) % 1024;
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] d);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{d[i]}};
        return m;
    endfunction

    task automatic wq(input logic [31:0] d, input logic [3:0] s);
        wd_q.push_back(d);
        ws_q.push_back(s);
    endtask

    // Drives one transaction from acceptance to completion, abort (abort_c) or reset (rst_c),
    // where abort_c/rst_c index the response cycles after acceptance (-1 = never).
    task automatic run_txn(input int u, input bit wr, input logic [31:0] addr, input int len,
                           input int burst, input int abort_c, input int rst_c);
        int          st;
        int          s_idx;
        logic [31:0] wd;
        logic [3:0]  ws;
        st    = (u == 1) ? 2 : 0;
        s_idx = int'(addr[11:2]);
        pred_q.delete();
        obs_q.delete();
        rdy_q.delete();
        req[u].valid    = 1'b1;
        req[u].is_write = wr;
        req[u].size     = 2'($urandom);
        req[u].addr     = addr;
        req[u].strobe   = 4'($urandom);
        req[u].data     = $urandom;
        req[u].len      = 4'(len);
        req[u].burst    = 2'(burst);
        exp_r[u] = '0;
        exp_m[u] = '1;
        chk[u]   = 1'b1;
        t_acc    = cyc;
        step();
        for (int c = 0; c < (len + 1) * (st + 1); c++) begin
            int k;
            int ix;
            bit beat;
            k    = c / (st + 1);
            beat = (c % (st + 1)) == st;
            ix   = widx(s_idx, k, len, burst);
            req[u].data   = $urandom;
            req[u].strobe = 4'($urandom);
            wd = req[u].data;
            ws = req[u].strobe;
            if (beat && wr) begin
                if (wd_q.size() > 0) wd = wd_q.pop_front();
                if (ws_q.size() > 0) ws = ws_q.pop_front();
                req[u].data   = wd;
                req[u].strobe = ws;
            end
            exp_r[u] = '0;
            exp_m[u] = '1;
            if (c == abort_c) begin
                req[u].valid = 1'b0;
                step();
                break;
            end
            if (c == rst_c) begin
                resetn = 1'b0;
                chk[u] = 1'b0;
                step();
                resetn = 1'b1;
                chk[u] = 1'b1;
                break;
            end
            if (beat) begin
                exp_r[u].ready = 1'b1;
                exp_r[u].last  = (k == len);
                if (!wr) begin
                    exp_r[u].data = mmem[u][ix];
                    exp_m[u]      = bmask(mdef[u][ix]);
                    pred_q.push_back(mmem[u][ix]);
                end
            end
            step();
            if (beat && wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (ws[i]) begin
                        mmem[u][ix][8*i +: 8] = wd[8*i +: 8];
                        mdef[u][ix][i]        = 1'b1;
                    end
                end
            end
        end
        req[u].valid = 1'b0;
        exp_r[u] = '0;
        exp_m[u] = '1;
        wd_q.delete();
        ws_q.delete();
    endtask

    task automatic check_seq(input string name);
        check($sformatf("%s beats", name), 32'(obs_q.size()), 32'(want_q.size()));
        foreach (want_q[i]) begin
            check($sformatf("%s dut beat%0d", name, i), (i < obs_q.size()) ? obs_q[i] : 32'hxxxxxxxx, want_q[i]);
            check($sformatf("%s model beat%0d", name, i), (i < pred_q.size()) ? pred_q[i] : 32'hxxxxxxxx, want_q[i]);
        end
        want_q.delete();
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            req[u]   = '0;
            exp_r[u] = '0;
            exp_m[u] = '1;
            chk[u]   = 1'b0;
        end
        // reset held for three edges with a request pending
        req[0].valid = 1'b1;
        req[0].addr  = 32'h300;
        step();
        chk[0] = 1'b1;
        chk[1] = 1'b1;
        step();
        step();
        resetn = 1'b1;
        run_txn(0, 1'b0, 32'h300, 0, 1, -1, -1);
        check("reset first ready cycle", 32'(rdy_q.size() > 0 ? rdy_q[0] : -1), 32'(t_acc + 1));

        wq(32'hDEADBEEF, 4'b1111);
        run_txn(0, 1'b1, 32'h10, 0, 1, -1, -1);
        check("single write ready cycle", 32'(rdy_q.size() > 0 ? rdy_q[0] : -1), 32'(t_acc + 1));
        wq(32'h0000AA00, 4'b0010);
        run_txn(0, 1'b1, 32'h10, 0, 1, -1, -1);
        want_q = '{32'hDEADAAEF};
        run_txn(0, 1'b0, 32'h10, 0, 1, -1, -1);
        check_seq("merged read");
        want_q = '{32'hDEADAAEF};
        run_txn(0, 1'b0, 32'h0000_1012, 0, 0, -1, -1);
        check_seq("alias read");

        for (int i = 1; i <= 4; i++) wq(32'(i), 4'b1111);
        run_txn(0, 1'b1, 32'h20, 3, 1, -1, -1);
        want_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_txn(0, 1'b0, 32'h20, 3, 1, -1, -1);
        check_seq("incr read");
        want_q = '{32'd3, 32'd4, 32'd1, 32'd2};
        run_txn(0, 1'b0, 32'h28, 3, 2, -1, -1);
        check_seq("wrap read");
        want_q = '{32'd1, 32'd1, 32'd1};
        run_txn(0, 1'b0, 32'h20, 2, 0, -1, -1);
        check_seq("fixed read");

        for (int i = 0; i < 4; i++) wq(32'hA0A0_0000 + 32'(i), 4'b1111);
        run_txn(0, 1'b1, 32'h80, 3, 1, -1, -1);
        for (int i = 0; i < 4; i++) wq(32'hE0E0_0000 + 32'(i), 4'b1111);
        run_txn(0, 1'b1, 32'h80, 3, 1, 1, -1);
        want_q = '{32'hE0E0_0000, 32'hA0A0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        run_txn(0, 1'b0, 32'h80, 3, 1, -1, -1);
        check_seq("abort read");
        for (int i = 0; i < 4; i++) wq(32'hC0C0_0000 + 32'(i), 4'b1111);
        run_txn(0, 1'b1, 32'h80, 3, 1, -1, 2);
        want_q = '{32'hC0C0_0000, 32'hC0C0_0001, 32'hA0A0_0002, 32'hA0A0_0003};
        run_txn(0, 1'b0, 32'h80, 3, 1, -1, -1);
        check_seq("reset mid-burst read");

        wq(32'd5, 4'b1111);
        wq(32'd6, 4'b1111);
        run_txn(1, 1'b1, 32'h40, 1, 1, -1, -1);
        want_q = '{32'd5, 32'd6};
        run_txn(1, 1'b0, 32'h40, 1, 1, -1, -1);
        check("stall beat0 cycle", 32'(rdy_q.size() > 0 ? rdy_q[0] : -1), 32'(t_acc + 3));
        check("stall beat1 cycle", 32'(rdy_q.size() > 1 ? rdy_q[1] : -1), 32'(t_acc + 6));
        check_seq("stall read");

        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 150; n++) begin
                int len;
                int ab;
                len = $urandom_range(0, 15);
                ab  = -1;
                if ($urandom_range(0, 9) == 0) ab = $urandom_range(0, (len + 1) * (u * 2 + 1) - 1);
                run_txn(u, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_F07F, len,
                        $urandom_range(0, 3), ab, -1);
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        step();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
